// File: rtl/fas_pkg.sv
// Shared constants and scheduler state type for the FAS frame scheduler.
package fas_pkg;
    localparam int DW     = 16;
    localparam int N      = 16;
    localparam int AW     = 4;
    localparam int FW     = 4;
    localparam int TO_CYC = 64;
    localparam int CW     = 10;
    localparam int TW     = $clog2(TO_CYC);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        FFT   = 2'd2,
        ANA   = 2'd3
    } sched_state_t;

    // Flat buffer index: bank selects the upper half of the 2xN storage.
    function automatic logic [AW:0] buf_addr(input logic bank, input logic [AW-1:0] addr);
        return {bank, addr};
    endfunction
endpackage

// File: rtl/fas_frame_sched_if.sv
// Sample, FFT and analysis handshake bundle between the scheduler and its neighbours.
interface fas_frame_sched_if;
    import fas_pkg::*;

    logic          fir_valid;
    logic [DW-1:0] fir_d;
    logic [AW-1:0] fft_rd_addr;
    logic [DW-1:0] fft_rd_data;
    logic          fft_start;
    logic          fft_done;
    logic          ana_start;
    logic          ana_done;
    logic [FW-1:0] ana_freq;
    logic          done;
    logic [FW-1:0] freq;
    logic [CW-1:0] frame_cnt;
    logic          ovf;
    logic          err;

    modport slave (
        input  fir_valid, fir_d, fft_rd_addr, fft_done, ana_done, ana_freq,
        output fft_rd_data, fft_start, ana_start, done, freq, frame_cnt, ovf, err
    );

    modport master (
        output fir_valid, fir_d, fft_rd_addr, fft_done, ana_done, ana_freq,
        input  fft_rd_data, fft_start, ana_start, done, freq, frame_cnt, ovf, err
    );
endinterface

// File: rtl/fas_pingpong_buf.sv
// Two-bank frame store: one write port and one registered read port.
module fas_pingpong_buf
    import fas_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en_i,
    input  logic          wr_bank_i,
    input  logic [AW-1:0] wr_addr_i,
    input  logic [DW-1:0] wr_data_i,
    input  logic          rd_bank_i,
    input  logic [AW-1:0] rd_addr_i,
    output logic [DW-1:0] rd_data_o
);
    logic [DW-1:0] mem_q [2*N];
    logic [DW-1:0] rd_data_q;

    // Sample storage; contents are not reset, only the read register is.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[buf_addr(wr_bank_i, wr_addr_i)] <= wr_data_i;
        end
    end

    // Registered read port, one cycle latency.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_q <= {DW{1'b0}};
        end else begin
            rd_data_q <= mem_q[buf_addr(rd_bank_i, rd_addr_i)];
        end
    end

    assign rd_data_o = rd_data_q;
endmodule

// File: rtl/fas_frame_sched.sv
// Packs FIR samples into ping-pong frames and sequences the FFT and analysis stages.
module fas_frame_sched
    import fas_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    fas_frame_sched_if.slave  bus
);
    logic          wr_bank_q, wr_bank_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [1:0]    full_q, full_d;
    logic          rd_bank_q, rd_bank_d;
    sched_state_t  state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          fft_start_q, fft_start_d;
    logic          ana_start_q, ana_start_d;
    logic          done_q, done_d;
    logic [FW-1:0] freq_q, freq_d;
    logic [CW-1:0] frame_cnt_q, frame_cnt_d;
    logic          ovf_q, ovf_d;
    logic          err_q, err_d;

    logic          wr_en_s;
    logic          set_full_s;
    logic          clr_full_s;
    logic [DW-1:0] rd_data_s;

    fas_pingpong_buf u_buf (
        .clk       (clk),
        .rst       (rst),
        .wr_en_i   (wr_en_s),
        .wr_bank_i (wr_bank_q),
        .wr_addr_i (wr_ptr_q),
        .wr_data_i (bus.fir_d),
        .rd_bank_i (rd_bank_q),
        .rd_addr_i (bus.fft_rd_addr),
        .rd_data_o (rd_data_s)
    );

    // Write side: fill the current bank, drop samples while it is still full.
    always_comb begin
        wr_en_s    = 1'b0;
        set_full_s = 1'b0;
        wr_bank_d  = wr_bank_q;
        wr_ptr_d   = wr_ptr_q;
        ovf_d      = ovf_q;
        if (bus.fir_valid) begin
            if (!full_q[wr_bank_q]) begin
                wr_en_s = 1'b1;
                if (wr_ptr_q == AW'(N-1)) begin
                    set_full_s = 1'b1;
                    wr_bank_d  = ~wr_bank_q;
                    wr_ptr_d   = {AW{1'b0}};
                end else begin
                    wr_ptr_d = wr_ptr_q + AW'(1);
                end
            end else begin
                ovf_d = 1'b1;
            end
        end else begin
            wr_en_s = 1'b0;
        end
    end

    // Set and clear always target different banks, so plain OR/AND-NOT merge is safe.
    always_comb begin
        full_d[0] = (full_q[0] | (set_full_s & ~wr_bank_q)) & ~(clr_full_s & ~rd_bank_q);
        full_d[1] = (full_q[1] | (set_full_s &  wr_bank_q)) & ~(clr_full_s &  rd_bank_q);
    end

    // Read scheduler: next state and registered pulse outputs.
    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        rd_bank_d   = rd_bank_q;
        clr_full_s  = 1'b0;
        fft_start_d = 1'b0;
        ana_start_d = 1'b0;
        done_d      = 1'b0;
        freq_d      = freq_q;
        frame_cnt_d = frame_cnt_q;
        err_d       = err_q;
        case (state_q)
            IDLE: begin
                if (full_q[rd_bank_q]) begin
                    state_d     = START;
                    fft_start_d = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            START: begin
                timer_d = {TW{1'b0}};
                state_d = FFT;
            end
            FFT: begin
                if (bus.fft_done) begin
                    clr_full_s  = 1'b1;
                    rd_bank_d   = ~rd_bank_q;
                    ana_start_d = 1'b1;
                    state_d     = ANA;
                end else if (timer_q == TW'(TO_CYC-1)) begin
                    // Abandon the frame so the writer can reuse the bank.
                    err_d      = 1'b1;
                    clr_full_s = 1'b1;
                    rd_bank_d  = ~rd_bank_q;
                    state_d    = IDLE;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            ANA: begin
                if (bus.ana_done) begin
                    freq_d      = bus.ana_freq;
                    done_d      = 1'b1;
                    frame_cnt_d = frame_cnt_q + CW'(1);
                    state_d     = IDLE;
                end else begin
                    state_d = ANA;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_bank_q   <= 1'b0;
            wr_ptr_q    <= {AW{1'b0}};
            full_q      <= 2'b00;
            rd_bank_q   <= 1'b0;
            state_q     <= IDLE;
            timer_q     <= {TW{1'b0}};
            fft_start_q <= 1'b0;
            ana_start_q <= 1'b0;
            done_q      <= 1'b0;
            freq_q      <= {FW{1'b0}};
            frame_cnt_q <= {CW{1'b0}};
            ovf_q       <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            wr_bank_q   <= wr_bank_d;
            wr_ptr_q    <= wr_ptr_d;
            full_q      <= full_d;
            rd_bank_q   <= rd_bank_d;
            state_q     <= state_d;
            timer_q     <= timer_d;
            fft_start_q <= fft_start_d;
            ana_start_q <= ana_start_d;
            done_q      <= done_d;
            freq_q      <= freq_d;
            frame_cnt_q <= frame_cnt_d;
            ovf_q       <= ovf_d;
            err_q       <= err_d;
        end
    end

    assign bus.fft_rd_data = rd_data_s;
    assign bus.fft_start   = fft_start_q;
    assign bus.ana_start   = ana_start_q;
    assign bus.done        = done_q;
    assign bus.freq        = freq_q;
    assign bus.frame_cnt   = frame_cnt_q;
    assign bus.ovf         = ovf_q;
    assign bus.err         = err_q;
endmodule
